// File: rtl/if_id.sv
// rtl/if_id.sv - IF/ID pipeline register with stall hold and flush-to-bubble
module if_id #(
    parameter int PC_W    = 12,
    parameter int INSTR_W = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [PC_W-1:0]    pc_4,
    input  logic [INSTR_W-1:0] instruction,
    input  logic               clear,
    input  logic               go_one,
    input  logic               go_two,
    output logic [PC_W-1:0]    pc_4_out,
    output logic [INSTR_W-1:0] instruction_out
);

    // An all-zero instruction word is sll $0,$0,0, so a bubble needs no valid bit.
    localparam logic [PC_W-1:0]    PC_BUBBLE    = '0;
    localparam logic [INSTR_W-1:0] INSTR_BUBBLE = '0;

    logic [PC_W-1:0]    pc_q;
    logic [INSTR_W-1:0] instr_q;
    logic               go;

    // Either stall source may hold the stage independently.
    assign go = go_one & go_two;

    // Reset is tested first so undriven inputs during reset never reach the state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q    <= PC_BUBBLE;
            instr_q <= INSTR_BUBBLE;
        end else if (clear) begin
            pc_q    <= PC_BUBBLE;
            instr_q <= INSTR_BUBBLE;
        end else if (go) begin
            pc_q    <= pc_4;
            instr_q <= instruction;
        end
    end

    assign pc_4_out        = pc_q;
    assign instruction_out = instr_q;

endmodule

// File: tb/tb_if_id.sv
// tb/tb_if_id.sv - self-checking bench for if_id against a rule-level reference model
module tb_if_id;

    localparam int PC_W    = 12;
    localparam int INSTR_W = 32;

    logic               clk = 1'b0;
    logic               rst_n;
    logic [PC_W-1:0]    pc_4;
    logic [INSTR_W-1:0] instruction;
    logic               clear;
    logic               go_one;
    logic               go_two;
    logic [PC_W-1:0]    pc_4_out;
    logic [INSTR_W-1:0] instruction_out;

    logic [PC_W-1:0]    exp_pc;
    logic [INSTR_W-1:0] exp_instr;
    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    if_id #(.PC_W(PC_W), .INSTR_W(INSTR_W)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .pc_4            (pc_4),
        .instruction     (instruction),
        .clear           (clear),
        .go_one          (go_one),
        .go_two          (go_two),
        .pc_4_out        (pc_4_out),
        .instruction_out (instruction_out)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask

    // One rising edge: the model applies the first matching rule to the inputs
    // present at that edge, then both outputs are compared 1 ns later.
    task automatic tick(input string tag);
        @(posedge clk);
        if (rst_n !== 1'b1 || clear === 1'b1) begin
            exp_pc    = '0;
            exp_instr = '0;
        end else if (go_one === 1'b1 && go_two === 1'b1) begin
            exp_pc    = pc_4;
            exp_instr = instruction;
        end
        #1;
        check({tag, "_pc"}, {52'b0, pc_4_out}, {52'b0, exp_pc});
        check({tag, "_instr"}, {32'b0, instruction_out}, {32'b0, exp_instr});
    endtask

    task automatic drive(input logic [PC_W-1:0] p, input logic [INSTR_W-1:0] i);
        pc_4        = p;
        instruction = i;
    endtask

    initial begin
        rst_n  = 1'b0;
        clear  = 1'b0;
        go_one = 1'b1;
        go_two = 1'b1;
        drive(12'h00F, 32'h0001_0000);
        exp_pc    = '0;
        exp_instr = '0;

        tick("reset0");
        tick("reset1");

        // Unknown inputs while in reset must not leak through.
        pc_4        = 'x;
        instruction = 'x;
        clear       = 1'bx;
        go_one      = 1'bx;
        tick("reset_x");
        clear  = 1'b0;
        go_one = 1'b1;
        drive(12'h00F, 32'h0001_0000);

        rst_n = 1'b1;
        tick("pass0");
        drive(12'h010, 32'h2008_0005);
        tick("pass1");
        drive(12'h00F, 32'h0001_0000);
        tick("pass2");

        clear = 1'b1;
        for (int k = 0; k < 10; k++) tick("flush");
        clear = 1'b0;
        tick("flush_exit");

        drive(12'h004, 32'h8C01_0000);
        tick("stall_load");
        go_one = 1'b0;
        drive(12'h008, 32'hAC01_0004);
        for (int k = 0; k < 3; k++) tick("stall_one");
        go_one = 1'b1;
        go_two = 1'b0;
        for (int k = 0; k < 3; k++) tick("stall_two");
        go_two = 1'b1;
        tick("resume");

        drive(12'h004, 32'h8C01_0000);
        tick("reload");
        go_one = 1'b0;
        clear  = 1'b1;
        tick("flush_over_stall");
        go_one = 1'b1;
        clear  = 1'b0;

        drive(12'h123, 32'hDEAD_BEEF);
        tick("pre_glitch");
        drive(12'h456, 32'h1234_5678);
        rst_n = 1'b0;
        #3;
        rst_n = 1'b1;
        #1;
        check("glitch_pc", {52'b0, pc_4_out}, {52'b0, exp_pc});
        check("glitch_instr", {32'b0, instruction_out}, {32'b0, exp_instr});
        tick("post_glitch");

        rst_n = 1'b0;
        clear = 1'b1;
        tick("reset_clear_go");
        rst_n = 1'b1;
        clear = 1'b0;

        for (int n = 0; n < 400; n++) begin
            rst_n  = ($urandom_range(0, 19) != 0);
            clear  = ($urandom_range(0, 7) == 0);
            go_one = ($urandom_range(0, 3) != 0);
            go_two = ($urandom_range(0, 3) != 0);
            drive(PC_W'($urandom), $urandom);
            tick("rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/if_id.md
# if_id

The IF/ID pipeline register of the 5-stage MIPS core sits between instruction fetch and instruction decode. It captures the fetched instruction and its PC+4 value on each rising clock edge. It holds them while the pipeline is stalled. It replaces them with a bubble (all zeros) when the front end is flushed.

## Interface
Parameters:
- PC_W, default 12: width of the PC+4 field (word-addressed instruction memory index).
- INSTR_W, default 32: width of the instruction field.

Ports:
- clk, input, 1: single clock. All state changes on the rising edge.
- rst_n, input, 1: reset, synchronous and active-low.
- pc_4, input, PC_W: PC+4 of the instruction currently being fetched.
- instruction, input, INSTR_W: fetched instruction word.
- clear, input, 1: flush request, active-high. Loads a bubble.
- go_one, input, 1: advance enable from the first stall source, active-high.
- go_two, input, 1: advance enable from the second stall source, active-high.
- pc_4_out, output, PC_W: registered PC+4 presented to decode.
- instruction_out, output, INSTR_W: registered instruction presented to decode.

## Operation
- Internal state is two registers, pc_q (PC_W) and instr_q (INSTR_W).
- Outputs are driven directly from these registers. There is no combinational path from any input to any output.
- The advance condition is go = go_one AND go_two. Either source deasserting stalls the stage.
- At each rising edge of clk, the first matching rule in this priority order applies:
  1. rst_n = 0: pc_q <= 0, instr_q <= 0.
  2. clear = 1: pc_q <= 0, instr_q <= 0. Flush wins over stall: clear takes effect even when go = 0.
  3. go = 1: pc_q <= pc_4, instr_q <= instruction.
  4. Otherwise (stall): pc_q and instr_q hold their values.
- A bubble is instruction_out = 32'h0000_0000, which is the MIPS NOP (sll $0,$0,0). Decode needs no separate valid bit.
- Inputs are sampled only at the clock edge. Changes between edges have no effect.
- X or Z on any input while rst_n = 0 must not propagate to the outputs.

## Timing
- Latency is 1 cycle. A value presented on pc_4/instruction before edge N appears on the outputs after edge N, when go = 1, clear = 0 and rst_n = 1.
- Throughput is one instruction per cycle while go = 1.
- Reset value is pc_4_out = 0 and instruction_out = 0. This holds from the first edge with rst_n = 0 and for every edge while rst_n stays low.
- Before the first reset edge, output values are undefined.
- Releasing rst_n: the first edge with rst_n = 1 applies rules 2–4 normally. There is no extra dead cycle.
- Reset mid-stall or mid-clear: reset dominates and the result is zeros either way.
- Clear and go both high: the result is zeros. The incoming instruction is discarded.
- Clear asserted for k consecutive edges: the outputs are zero for those k cycles. The first edge after clear deasserts, with go = 1, loads the current inputs.
- Stall followed by resume: the held value remains until the first edge with go = 1, which loads the inputs current at that edge. No fetch is replayed internally; replay is the fetch stage's responsibility.

## Test plan
- Reset: rst_n = 0 for 2 edges with pc_4 = 12'h00F and instruction = 32'h0001_0000 -> both outputs 0 after the first edge and stay 0.
- Pass-through: rst_n = 1, go_one = go_two = 1, clear = 0, pc_4 = 12'h00F, instruction = 32'h0001_0000 -> after the next edge pc_4_out = 12'h00F and instruction_out = 32'h0001_0000. Then step pc_4 to 12'h010 and instruction to 32'h2008_0005 -> the outputs follow exactly one edge later.
- Flush: while streaming, hold clear = 1 for 10 edges -> outputs are 0 for those 10 cycles. On the first edge after clear drops, the outputs equal the current inputs again (12'h00F / 32'h0001_0000).
- Stall per source: load 12'h004 / 32'h8C01_0000, then set go_one = 0 and change the inputs to 12'h008 / 32'hAC01_0004 for 3 edges -> outputs hold 12'h004 / 32'h8C01_0000. Repeat with go_two = 0 -> same hold. Restore both -> 12'h008 / 32'hAC01_0004 after one edge.
- Flush over stall: go_one = 0 and clear = 1 on the same edge with outputs at 12'h004 / 32'h8C01_0000 -> outputs become 0.
- Synchronous reset check: drop rst_n for less than a clock period between edges -> outputs are unchanged until an edge samples rst_n = 0. Assert rst_n = 0 together with clear = 1 and go = 1 -> zeros.
